// File: rtl/adpcm_pkg.sv
// Shared constants for the ADPCM reconstruction/adaptation stage:
// IMA step table, index adjustment table and the FSM state encoding.
package adpcm_pkg;

   localparam int IDX_MAX = 88;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECON  = 2'd1,
      ST_COMMIT = 2'd2
   } adpcm_state_e;

   localparam logic [15:0] STEP_TABLE [0:88] = '{
      16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
      16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
      16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
      16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
      16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
      16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
      16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
      16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
      16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
      16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
      16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
      16'd32767
   };

   localparam logic signed [4:0] INDEX_ADJ [0:7] = '{
      -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
   };

endpackage

// File: rtl/adpcm_step_rom.sv
// Combinational step-size lookup; indices above IDX_MAX read the last entry
// so the table is never addressed out of range.
module adpcm_step_rom
   import adpcm_pkg::*;
#(
   parameter int IDX_W  = 7,
   parameter int DATA_W = 16
)(
   input  logic [IDX_W-1:0]  index,
   output logic [DATA_W-1:0] step
);

   logic [IDX_W-1:0] safe_idx;

   always_comb begin
      safe_idx = index;
      if (index > IDX_W'(IDX_MAX)) safe_idx = IDX_W'(IDX_MAX);
      step = DATA_W'(STEP_TABLE[safe_idx]);
   end

endmodule

// File: rtl/adpcm_recon_update.sv
// ADPCM decoder/adaptation stage: reconstructs diffq, updates the saturated
// predictor, step index and step size. Optional ADPCM_SYNC_LOAD_EN adds a state load port.
module adpcm_recon_update
   import adpcm_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 7
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     code_valid,
   input  logic [3:0]               code,
   output logic                     code_ready,
   output logic signed [DATA_W-1:0] predicted,
   output logic [DATA_W-1:0]        step_size,
   output logic [IDX_W-1:0]         step_index,
   output logic                     upd_valid
`ifdef ADPCM_SYNC_LOAD_EN
   ,
   input  logic                     load_valid,
   input  logic signed [DATA_W-1:0] load_pred,
   input  logic [IDX_W-1:0]         load_index
`endif
);

   function automatic logic [DATA_W:0] calc_diffq(input logic [DATA_W-1:0] step,
                                                  input logic [2:0] mag);
      logic [DATA_W:0] s;
      s = {1'b0, step};
      calc_diffq = (s >> 3)
                 + (mag[2] ? s        : '0)
                 + (mag[1] ? (s >> 1) : '0)
                 + (mag[0] ? (s >> 2) : '0);
   endfunction

   // Overflow iff the top three bits of the wide sum disagree.
   function automatic logic signed [DATA_W-1:0] sat_sample(input logic signed [DATA_W+1:0] v);
      if (v[DATA_W+1:DATA_W-1] == 3'b000 || v[DATA_W+1:DATA_W-1] == 3'b111)
         sat_sample = v[DATA_W-1:0];
      else if (v[DATA_W+1])
         sat_sample = {1'b1, {(DATA_W-1){1'b0}}};
      else
         sat_sample = {1'b0, {(DATA_W-1){1'b1}}};
   endfunction

   function automatic logic [IDX_W-1:0] clamp_index(input logic signed [IDX_W+1:0] v);
      if (v < 0)
         clamp_index = '0;
      else if (v > signed'((IDX_W+2)'(IDX_MAX)))
         clamp_index = IDX_W'(IDX_MAX);
      else
         clamp_index = v[IDX_W-1:0];
   endfunction

   adpcm_state_e state_q, state_d;
   logic                     accept;
   logic                     load_go;
   logic signed [DATA_W-1:0] load_pred_w;
   logic [IDX_W-1:0]         load_idx_w;

`ifdef ADPCM_SYNC_LOAD_EN
   assign load_go     = (state_q == ST_IDLE) && load_valid;
   assign load_pred_w = load_pred;
   assign load_idx_w  = clamp_index(signed'({2'b00, load_index}));
`else
   assign load_go     = 1'b0;
   assign load_pred_w = '0;
   assign load_idx_w  = '0;
`endif

   always_comb begin
      state_d    = state_q;
      code_ready = 1'b0;
      accept     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!load_go) begin
               code_ready = 1'b1;
               if (code_valid) begin
                  accept  = 1'b1;
                  state_d = ST_RECON;
               end
            end
         end
         ST_RECON:  state_d = ST_COMMIT;
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Stage p0: latch accepted code
   logic [3:0] code_p0;

   always_ff @(posedge clk) begin
      if (accept) code_p0 <= code;
   end

   // Stage p1: reconstruct quantized difference from the current step
   logic [DATA_W:0] diffq_p1;

   always_ff @(posedge clk) begin
      if (state_q == ST_RECON) diffq_p1 <= calc_diffq(step_size, code_p0[2:0]);
   end

   // Stage p2: predictor/index update, committed at the end of COMMIT
   logic signed [DATA_W+1:0] pred_ext, diff_ext, sum_p2;
   logic signed [IDX_W+1:0]  idx_sum;
   logic [IDX_W-1:0]         new_idx_p2;
   logic [IDX_W-1:0]         rom_idx;
   logic [DATA_W-1:0]        rom_step;

   always_comb begin
      pred_ext   = (DATA_W+2)'(predicted);
      diff_ext   = signed'({1'b0, diffq_p1});
      sum_p2     = code_p0[3] ? (pred_ext - diff_ext) : (pred_ext + diff_ext);
      idx_sum    = signed'({2'b00, step_index}) + (IDX_W+2)'(INDEX_ADJ[code_p0[2:0]]);
      new_idx_p2 = clamp_index(idx_sum);
      rom_idx    = load_go ? load_idx_w : new_idx_p2;
   end

   adpcm_step_rom #(
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W)
   ) u_step_rom (
      .index (rom_idx),
      .step  (rom_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         upd_valid  <= 1'b0;
         predicted  <= '0;
         step_index <= '0;
         step_size  <= DATA_W'(STEP_TABLE[0]);
      end else begin
         state_q   <= state_d;
         upd_valid <= (state_q == ST_COMMIT) || load_go;
         if (state_q == ST_COMMIT) begin
            predicted  <= sat_sample(sum_p2);
            step_index <= new_idx_p2;
            step_size  <= rom_step;
         end else if (load_go) begin
            predicted  <= load_pred_w;
            step_index <= load_idx_w;
            step_size  <= rom_step;
         end
      end
   end

endmodule

// File: tb/tb_adpcm_recon_update.sv
// Directed bench for adpcm_recon_update; load scenarios build only with ADPCM_SYNC_LOAD_EN.
module tb_adpcm_recon_update;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               code_valid = 1'b0;
   logic [3:0]         code = 4'd0;
   logic               code_ready;
   logic signed [15:0] predicted;
   logic [15:0]        step_size;
   logic [6:0]         step_index;
   logic               upd_valid;
`ifdef ADPCM_SYNC_LOAD_EN
   logic               load_valid = 1'b0;
   logic signed [15:0] load_pred = '0;
   logic [6:0]         load_index = '0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   adpcm_recon_update #(.DATA_W(16), .IDX_W(7)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_valid (code_valid),
      .code       (code),
      .code_ready (code_ready),
      .predicted  (predicted),
      .step_size  (step_size),
      .step_index (step_index),
      .upd_valid  (upd_valid)
`ifdef ADPCM_SYNC_LOAD_EN
      ,
      .load_valid (load_valid),
      .load_pred  (load_pred),
      .load_index (load_index)
`endif
   );

   task automatic apply_reset();
      code_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Offers a code, waits for acceptance, returns negedges from accept edge to upd_valid (-1 = none).
   task automatic send_code(input logic [3:0] c, output int lat);
      int w;
      @(negedge clk);
      code = c;
      code_valid = 1'b1;
      w = 0;
      lat = -1;
      while (!code_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!code_ready) begin
         code_valid = 1'b0;
         return;
      end
      @(negedge clk);
      code_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (upd_valid) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (predicted !== 16'sd0) begin bad++; $display("FAIL reset_pred got=%0d want=0", predicted); end
      total++; if (step_size !== 16'd7) begin bad++; $display("FAIL reset_step got=%0d want=7", step_size); end
      total++; if (step_index !== 7'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", step_index); end
      total++; if (code_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", code_ready); end
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL reset_upd got=%b want=0", upd_valid); end
   endtask

   task automatic test_pos_code();
      int lat;
      apply_reset();
      send_code(4'b0111, lat);
      total++; if (lat != 3) begin bad++; $display("FAIL pos_latency got=%0d want=3", lat); end
      total++; if (predicted !== 16'sd11) begin bad++; $display("FAIL pos_pred got=%0d want=11", predicted); end
      total++; if (step_index !== 7'd8) begin bad++; $display("FAIL pos_idx got=%0d want=8", step_index); end
      total++; if (step_size !== 16'd16) begin bad++; $display("FAIL pos_step got=%0d want=16", step_size); end
      @(negedge clk);
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL pos_upd_pulse got=%b want=0", upd_valid); end
      total++; if (predicted !== 16'sd11) begin bad++; $display("FAIL pos_pred_hold got=%0d want=11", predicted); end
   endtask

   task automatic test_neg_code();
      int lat;
      apply_reset();
      send_code(4'b1111, lat);
      total++; if (lat != 3) begin bad++; $display("FAIL neg_latency got=%0d want=3", lat); end
      total++; if (predicted !== -16'sd11) begin bad++; $display("FAIL neg_pred got=%0d want=-11", predicted); end
      total++; if (step_index !== 7'd8) begin bad++; $display("FAIL neg_idx got=%0d want=8", step_index); end
   endtask

   task automatic test_zero_code();
      int lat;
      apply_reset();
      send_code(4'b0000, lat);
      total++; if (lat != 3) begin bad++; $display("FAIL zero_latency got=%0d want=3", lat); end
      total++; if (predicted !== 16'sd0) begin bad++; $display("FAIL zero_pred got=%0d want=0", predicted); end
      total++; if (step_index !== 7'd0) begin bad++; $display("FAIL zero_idx_clamp got=%0d want=0", step_index); end
      total++; if (step_size !== 16'd7) begin bad++; $display("FAIL zero_step got=%0d want=7", step_size); end
   endtask

   task automatic test_saturation();
      int lat;
      int exp_pred [11] = '{11, 41, 104, 240, 533, 1164, 2521, 5431, 11667, 25039, 32767};
      int exp_step [11] = '{16, 34, 73, 157, 337, 724, 1552, 3327, 7132, 15289, 32767};
      apply_reset();
      for (int i = 0; i < 11; i++) begin
         send_code(4'b0111, lat);
         total++; if (predicted !== 16'(exp_pred[i])) begin bad++; $display("FAIL sat_chain_pred[%0d] got=%0d want=%0d", i, predicted, exp_pred[i]); end
         total++; if (step_index !== 7'(8 * (i + 1))) begin bad++; $display("FAIL sat_chain_idx[%0d] got=%0d want=%0d", i, step_index, 8 * (i + 1)); end
         total++; if (step_size !== 16'(exp_step[i])) begin bad++; $display("FAIL sat_chain_step[%0d] got=%0d want=%0d", i, step_size, exp_step[i]); end
      end
      send_code(4'b0111, lat);
      total++; if (predicted !== 16'sd32767) begin bad++; $display("FAIL sat_pos_hold got=%0d want=32767", predicted); end
      total++; if (step_index !== 7'd88) begin bad++; $display("FAIL sat_idx_max got=%0d want=88", step_index); end
      send_code(4'b1111, lat);
      total++; if (predicted !== -16'sd28669) begin bad++; $display("FAIL sat_neg_step got=%0d want=-28669", predicted); end
      send_code(4'b1111, lat);
      total++; if (predicted !== -16'sd32768) begin bad++; $display("FAIL sat_neg_clip got=%0d want=-32768", predicted); end
      total++; if (lat != 3) begin bad++; $display("FAIL sat_latency got=%0d want=3", lat); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      @(negedge clk);
      code = 4'b0111;
      code_valid = 1'b1;
      @(negedge clk);
      total++; if (code_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_recon got=%b want=0", code_ready); end
      @(negedge clk);
      total++; if (code_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_commit got=%b want=0", code_ready); end
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL b2b_upd_early got=%b want=0", upd_valid); end
      @(negedge clk);
      total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL b2b_upd1 got=%b want=1", upd_valid); end
      total++; if (predicted !== 16'sd11) begin bad++; $display("FAIL b2b_pred1 got=%0d want=11", predicted); end
      total++; if (code_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_upd got=%b want=1", code_ready); end
      @(negedge clk);
      code_valid = 1'b0;
      total++; if (code_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b want=0", code_ready); end
      repeat (2) @(negedge clk);
      total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL b2b_upd2 got=%b want=1", upd_valid); end
      total++; if (predicted !== 16'sd41) begin bad++; $display("FAIL b2b_pred2 got=%0d want=41", predicted); end
      total++; if (step_index !== 7'd16) begin bad++; $display("FAIL b2b_idx2 got=%0d want=16", step_index); end
      total++; if (step_size !== 16'd34) begin bad++; $display("FAIL b2b_step2 got=%0d want=34", step_size); end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic seen;
      apply_reset();
      send_code(4'b0111, lat);
      @(negedge clk);
      code = 4'b0111;
      code_valid = 1'b1;
      @(negedge clk);
      code_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++; if (predicted !== 16'sd0) begin bad++; $display("FAIL mid_rst_pred got=%0d want=0", predicted); end
      total++; if (step_index !== 7'd0) begin bad++; $display("FAIL mid_rst_idx got=%0d want=0", step_index); end
      total++; if (step_size !== 16'd7) begin bad++; $display("FAIL mid_rst_step got=%0d want=7", step_size); end
      total++; if (code_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", code_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (upd_valid !== 1'b0) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_no_upd got=%b want=0", seen); end
      total++; if (predicted !== 16'sd0) begin bad++; $display("FAIL mid_rst_pred_after got=%0d want=0", predicted); end
   endtask

`ifdef ADPCM_SYNC_LOAD_EN
   task automatic test_load();
      int lat;
      apply_reset();
      @(negedge clk);
      load_valid = 1'b1;
      load_pred  = 16'sd32760;
      load_index = 7'd100;
      code       = 4'b0000;
      code_valid = 1'b1;
      #1;
      total++; if (code_ready !== 1'b0) begin bad++; $display("FAIL load_ready got=%b want=0", code_ready); end
      @(negedge clk);
      load_valid = 1'b0;
      code_valid = 1'b0;
      total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL load_upd got=%b want=1", upd_valid); end
      total++; if (predicted !== 16'sd32760) begin bad++; $display("FAIL load_pred got=%0d want=32760", predicted); end
      total++; if (step_index !== 7'd88) begin bad++; $display("FAIL load_idx_clamp got=%0d want=88", step_index); end
      total++; if (step_size !== 16'd32767) begin bad++; $display("FAIL load_step got=%0d want=32767", step_size); end
      total++; if (code_ready !== 1'b1) begin bad++; $display("FAIL load_code_dropped got=%b want=1", code_ready); end
      send_code(4'b0111, lat);
      total++; if (predicted !== 16'sd32767) begin bad++; $display("FAIL load_sat_pos got=%0d want=32767", predicted); end
      total++; if (step_index !== 7'd88) begin bad++; $display("FAIL load_idx_hold got=%0d want=88", step_index); end
      @(negedge clk);
      load_valid = 1'b1;
      load_pred  = -16'sd32760;
      load_index = 7'd88;
      @(negedge clk);
      load_valid = 1'b0;
      total++; if (predicted !== -16'sd32760) begin bad++; $display("FAIL load_pred_neg got=%0d want=-32760", predicted); end
      send_code(4'b1111, lat);
      total++; if (predicted !== -16'sd32768) begin bad++; $display("FAIL load_sat_neg got=%0d want=-32768", predicted); end
   endtask
`endif

   initial begin
      test_reset();
      test_pos_code();
      test_neg_code();
      test_zero_code();
      test_saturation();
      test_back_to_back();
      test_reset_mid();
`ifdef ADPCM_SYNC_LOAD_EN
      test_load();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
